data_inf_intc_m2s_wrr_with_id: RTL and testbench



---
 rtl/data_inf_intc_m2s_wrr_with_id.sv | 82 ++++++++
 tb/tb_data_inf_intc_m2s_wrr_with_id.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_inf_intc_m2s_wrr_with_id.sv
// data_inf_intc_m2s_wrr_with_id: N-to-1 valid/ready arbiter (FIXED/RR/WRR) with burst quota and per-channel ID tagging.
module data_inf_intc_m2s_wrr_with_id #(
    parameter int    NUM    = 8,
    parameter int    DSIZE  = 32,
    parameter int    IDSIZE = 4,
    parameter int    WSIZE  = 4,
    parameter string MODE   = "RR",
    parameter int    NSIZE  = $clog2(NUM)
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [NUM-1:0][IDSIZE-1:0]    sid,
    input  logic [NUM-1:0][WSIZE-1:0]     quota,
    input  logic [NUM-1:0][DSIZE-1:0]     s_data,
    input  logic [NUM-1:0]                s_valid,
    output logic [NUM-1:0]                s_ready,
    output logic [DSIZE-1:0]              m_data,
    output logic [IDSIZE-1:0]             m_id,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [NSIZE-1:0]              grant_idx
);
    localparam bit FIXED = (MODE == "FIXED");
    localparam bit WRR   = (MODE == "WRR");

    typedef enum logic {IDLE, LOCK} state_t;
    state_t state;

    logic [NSIZE-1:0]  last, win, idx;
    logic [WSIZE-1:0]  cnt, eff_q;
    logic [IDSIZE-1:0] id_q;
    logic              can_load, hs;

    // Scan from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NUM; k >= 1; k--) begin
            idx = NSIZE'((FIXED ? k - 1 : int'(last) + k) % NUM);
            if (s_valid[idx]) win = idx;
        end
    end

    assign eff_q    = (WRR && quota[win] != '0) ? quota[win] : WSIZE'(1);
    assign can_load = !m_valid || m_ready;
    assign s_ready  = (state == LOCK && can_load) ? NUM'(1) << grant_idx : '0;
    assign hs       = state == LOCK && s_valid[grant_idx] && can_load;

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= '0;
            last      <= NSIZE'(NUM - 1);
            cnt       <= '0;
            id_q      <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_id      <= '0;
        end else begin
            if (hs) begin
                m_valid <= 1'b1;
                m_data  <= s_data[grant_idx];
                m_id    <= id_q;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (state == IDLE && |s_valid) begin
                state     <= LOCK;
                grant_idx <= win;
                id_q      <= sid[win];
                cnt       <= eff_q;
            end else if (state == LOCK) begin
                if (hs) cnt <= cnt - WSIZE'(1);
                // A channel that goes idle forfeits the rest of its quota.
                if ((hs && cnt == WSIZE'(1)) || !s_valid[grant_idx]) begin
                    state <= IDLE;
                    last  <= grant_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_inf_intc_m2s_wrr_with_id.sv
// tb_data_inf_intc_m2s_wrr_with_id: FIXED, RR and WRR instances driven in parallel and checked against a behavioural model.
module tb_data_inf_intc_m2s_wrr_with_id;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_ready = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0][3:0]  sid, quota;
    logic [N-1:0][31:0] s_data [3];
    logic [N-1:0]       s_valid [3];
    logic [N-1:0]       s_ready [3];
    logic [31:0]        m_data [3];
    logic [3:0]         m_id [3];
    logic               m_valid [3];
    logic [2:0]         grant_idx [3];

    data_inf_intc_m2s_wrr_with_id #(.NUM(N), .DSIZE(32), .IDSIZE(4), .WSIZE(4), .MODE("FIXED")) u_fixed (
        .clock(clk), .rst(rst), .sid(sid), .quota(quota), .s_data(s_data[0]), .s_valid(s_valid[0]),
        .s_ready(s_ready[0]), .m_data(m_data[0]), .m_id(m_id[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready), .grant_idx(grant_idx[0]));
    data_inf_intc_m2s_wrr_with_id #(.NUM(N), .DSIZE(32), .IDSIZE(4), .WSIZE(4), .MODE("RR")) u_rr (
        .clock(clk), .rst(rst), .sid(sid), .quota(quota), .s_data(s_data[1]), .s_valid(s_valid[1]),
        .s_ready(s_ready[1]), .m_data(m_data[1]), .m_id(m_id[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready), .grant_idx(grant_idx[1]));
    data_inf_intc_m2s_wrr_with_id #(.NUM(N), .DSIZE(32), .IDSIZE(4), .WSIZE(4), .MODE("WRR")) u_wrr (
        .clock(clk), .rst(rst), .sid(sid), .quota(quota), .s_data(s_data[2]), .s_valid(s_valid[2]),
        .s_ready(s_ready[2]), .m_data(m_data[2]), .m_id(m_id[2]), .m_valid(m_valid[2]),
        .m_ready(m_ready), .grant_idx(grant_idx[2]));

    // Sources: each channel offers beats {channel, sequence} while enabled and rem > 0.
    logic [N-1:0] en;
    int seq [3][N];
    int rem [3][N];
    bit hsf [3][N];

    // Model of each arbiter: which channel holds the grant, beats left, last winner, output register.
    bit          known = 1'b0;
    bit          busy [3];
    bit          mv [3];
    int          gi [3], left [3], last [3];
    logic [31:0] md [3];
    logic [3:0]  mid [3], idq [3];
    int          lid [3][$];
    logic [31:0] ldat [3][$];

    int total = 0;
    int bad = 0;

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic chk_ids(string nm, int d, int n, int e [10]);
        for (int k = 0; k < n; k++)
            chk(nm, d, (k < lid[d].size()) ? 32'(lid[d][k]) : 32'hFFFF_FFFF, 32'(e[k]));
    endtask

    task automatic drive();
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < N; c++) begin
                s_valid[d][c] = en[c] && rem[d][c] > 0;
                s_data[d][c]  = {8'(c), 24'(seq[d][c])};
            end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 3; d++) begin
            lid[d].delete();
            ldat[d].delete();
        end
    endtask

    task automatic model_cycle();
        for (int d = 0; d < 3; d++) begin
            logic [N-1:0] esr;
            bit h;
            int w, c;
            esr = '0;
            if (busy[d]) esr[gi[d]] = !mv[d] || m_ready;
            if (known) begin
                chk("m_valid", d, 32'(m_valid[d]), 32'(mv[d]));
                if (mv[d]) begin
                    chk("m_data", d, m_data[d], md[d]);
                    chk("m_id", d, 32'(m_id[d]), 32'(mid[d]));
                end
                chk("s_ready", d, 32'(s_ready[d]), 32'(esr));
                if (busy[d]) chk("grant_idx", d, 32'(grant_idx[d]), 32'(gi[d]));
            end
            for (int k = 0; k < N; k++) hsf[d][k] = s_valid[d][k] && s_ready[d][k];
            if (mv[d] && m_ready) begin
                lid[d].push_back(int'(mid[d]));
                ldat[d].push_back(md[d]);
            end
            if (rst) begin
                busy[d] = 1'b0; gi[d] = 0; last[d] = N - 1; mv[d] = 1'b0; md[d] = '0; mid[d] = '0;
                continue;
            end
            h = busy[d] && s_valid[d][gi[d]] && esr[gi[d]];
            if (h) begin
                mv[d] = 1'b1; md[d] = s_data[d][gi[d]]; mid[d] = idq[d];
            end else if (m_ready) begin
                mv[d] = 1'b0;
            end
            if (busy[d]) begin
                if (h) left[d]--;
                if ((h && left[d] == 0) || !s_valid[d][gi[d]]) begin
                    busy[d] = 1'b0;
                    last[d] = gi[d];
                end
            end else if (|s_valid[d]) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    c = (d == 0) ? k : (last[d] + 1 + k) % N;
                    if (w < 0 && s_valid[d][c]) w = c;
                end
                busy[d] = 1'b1;
                gi[d]   = w;
                idq[d]  = sid[w];
                left[d] = (d == 2) ? ((quota[w] == 0) ? 1 : int'(quota[w])) : 1;
            end
        end
        if (rst) known = 1'b1;
    endtask

    task automatic step(int n = 1);
        for (int i = 0; i < n; i++) begin
            drive();
            @(negedge clk);
            model_cycle();
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++)
                for (int c = 0; c < N; c++)
                    if (hsf[d][c]) begin
                        seq[d][c]++;
                        rem[d][c]--;
                    end
        end
        drive();
    endtask

    task automatic reload(int ch, int r);
        for (int d = 0; d < 3; d++) begin
            seq[d][ch] = 0;
            rem[d][ch] = r;
        end
    endtask

    int pat [4] = '{1, 0, 0, 1};

    initial begin
        for (int c = 0; c < N; c++) begin
            sid[c]   = 4'(c + 1);
            quota[c] = '0;
            reload(c, 1000);
        end
        quota[0] = 4'd1; quota[1] = 4'd2; quota[2] = 4'd3; quota[3] = 4'd4;
        en = 8'h0F;

        // Reset with channels valid, then round-robin / weighted round-robin traffic.
        step(3);
        for (int d = 0; d < 3; d++) begin
            chk("rst_s_ready", d, 32'(s_ready[d]), 32'h0);
            chk("rst_m_valid", d, 32'(m_valid[d]), 32'h0);
        end
        rst = 1'b0;
        clear_logs();
        step(32);
        chk_ids("fixed_ids", 0, 8, '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0});
        chk_ids("rr_ids", 1, 8, '{1, 2, 3, 4, 1, 2, 3, 4, 0, 0});
        chk_ids("wrr_ids", 2, 10, '{1, 2, 2, 3, 3, 3, 4, 4, 4, 4});
        chk("wrr_data1", 2, (ldat[2].size() > 2) ? ldat[2][2] : 32'hDEAD_BEEF, 32'h0100_0001);

        // Stall with a held beat, then reset mid-burst.
        m_ready = 1'b0;
        step(3);
        for (int d = 0; d < 3; d++) chk("held_m_valid", d, 32'(m_valid[d]), 32'h1);
        rst = 1'b1;
        step();
        for (int d = 0; d < 3; d++) begin
            chk("midrst_m_valid", d, 32'(m_valid[d]), 32'h0);
            chk("midrst_grant", d, 32'(grant_idx[d]), 32'h0);
        end

        // Back-pressure on a quota-4 grant of channel 3.
        en = 8'h08;
        reload(3, 1000);
        rst = 1'b0;
        clear_logs();
        for (int k = 0; k < 24; k++) begin
            m_ready = pat[k % 4][0];
            step();
        end
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 5; k++)
                chk("bp_data", d, (ldat[d].size() > k) ? ldat[d][k] : 32'hDEAD_BEEF, 32'h0300_0000 + 32'(k));

        // Early release: channel 2 stops after 3 beats; sid changes while it is locked.
        rst = 1'b1;
        m_ready = 1'b1;
        step();
        en = 8'h64;
        quota[2] = 4'd8; quota[5] = 4'd2; quota[6] = 4'd1;
        reload(2, 3); reload(5, 1000); reload(6, 1000);
        rst = 1'b0;
        clear_logs();
        step(2);
        sid[2] = 4'hF;
        step(12);
        for (int d = 0; d < 3; d++) rem[d][2] = 1000;
        step(20);
        chk_ids("early_wrr", 2, 6, '{3, 3, 3, 6, 6, 7, 0, 0, 0, 0});
        chk_ids("early_rr", 1, 4, '{3, 6, 7, 15, 0, 0, 0, 0, 0, 0});

        // Channels 0 and 5: FIXED starves 5; quota 0 acts as 1.
        rst = 1'b1;
        step();
        en = 8'h21;
        quota[0] = 4'd0;
        reload(0, 1000); reload(5, 1000);
        rst = 1'b0;
        clear_logs();
        step(24);
        chk_ids("starve_fixed", 0, 6, '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0});
        chk_ids("starve_rr", 1, 6, '{1, 6, 1, 6, 1, 6, 0, 0, 0, 0});
        chk_ids("starve_wrr", 2, 6, '{1, 6, 6, 1, 6, 6, 0, 0, 0, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
